// File: rtl/pd_prl_pkg.sv
// Shared types and constants for the USB-PD protocol-layer transmit path.
package pd_prl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONSTRUCT,
        ST_SEND,
        ST_WAIT_CRC,
        ST_CHECK_RETRY,
        ST_SUCCESS,
        ST_FAILURE,
        ST_DISCARD
    } prl_state_e;

    localparam logic [2:0] SOP_SOP    = 3'd0;
    localparam logic [2:0] SOP_PRIME  = 3'd1;
    localparam logic [2:0] SOP_DPRIME = 3'd2;

    localparam int MSGID_W = 3;

    localparam logic [11:0] CRC_TIMEOUT_DEF = 12'h111;

    // Bit positions of the transmit alerts inside the TCPC ALERT register.
    localparam int ALERT_TX_FAILED    = 4;
    localparam int ALERT_TX_DISCARDED = 5;
    localparam int ALERT_TX_SUCCESS   = 6;

endpackage

// File: rtl/pd_msgid_bank.sv
// One wrapping MessageID counter per SOP* type; clear has priority over increment.
module pd_msgid_bank
    import pd_prl_pkg::*;
#(
    parameter int N_SOP = 3
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            clr,
    input  logic                            inc,
    input  logic [2:0]                      inc_sel,
    output logic [N_SOP-1:0][MSGID_W-1:0]   cnt
);

    for (genvar g = 0; g < N_SOP; g++) begin : g_cnt
        logic [MSGID_W-1:0] cnt_q;

        always_ff @(posedge CLK or posedge reset) begin
            if (reset)
                cnt_q <= '0;
            else if (clr)
                cnt_q <= '0;
            else if (inc && (inc_sel == 3'(g)))
                cnt_q <= cnt_q + 1'b1;
        end

        assign cnt[g] = cnt_q;
    end

endmodule

// File: rtl/pd_prl_tx_engine.sv
// USB-PD protocol-layer transmit engine: streams a frame from the TX buffer to the
// PHY, waits for GoodCRC with retries, and raises success/failed/discarded alerts.
module pd_prl_tx_engine
    import pd_prl_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          MAX_BYTES   = 30,
    parameter int          N_RETRY     = 3,
    parameter logic [11:0] CRC_TIMEOUT = CRC_TIMEOUT_DEF,
    parameter int          N_SOP       = 3
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         tx_req,
    input  logic [2:0]                   tx_sop,
    input  logic [7:0]                   tx_byte_count,
    output logic [$clog2(MAX_BYTES)-1:0] buf_addr,
    input  logic [DATA_W-1:0]            buf_data,
    output logic                         phy_valid,
    output logic [DATA_W-1:0]            phy_data,
    output logic                         phy_last,
    input  logic                         phy_ready,
    input  logic                         crc_valid,
    input  logic [2:0]                   crc_msgid,
    input  logic [2:0]                   crc_sop,
    input  logic                         rx_discard,
    input  logic                         hard_reset,
    output logic [MSGID_W-1:0]           msgid,
    output logic                         busy,
    output logic                         alert_success,
    output logic                         alert_failed,
    output logic                         alert_discarded
);

    localparam int AW = $clog2(MAX_BYTES);
    localparam int SW = (N_SOP > 1) ? $clog2(N_SOP) : 1;
    localparam int RW = (N_RETRY > 0) ? $clog2(N_RETRY + 1) : 1;

    prl_state_e     state_q, state_d;
    logic [SW-1:0]  sop_q, sop_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     idx_q, idx_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [11:0]    timer_q, timer_d;
    logic           inv_alert_q, inv_alert_d;

    logic [N_SOP-1:0][MSGID_W-1:0] msgid_all;
    logic [MSGID_W-1:0]            msgid_cur;
    logic                          req_ok, crc_match, xfer, last_byte, discard_ok;

    pd_msgid_bank #(.N_SOP(N_SOP)) u_msgid_bank (
        .CLK     (CLK),
        .reset   (reset),
        .clr     (hard_reset),
        .inc     ((state_q == ST_SUCCESS) || (state_q == ST_FAILURE)),
        .inc_sel (3'(sop_q)),
        .cnt     (msgid_all)
    );

    assign msgid_cur = msgid_all[sop_q];
    assign msgid     = msgid_cur;
    assign busy      = (state_q != ST_IDLE);

    assign req_ok = (tx_sop < 3'(N_SOP)) && (tx_byte_count >= 8'd2) &&
                    (tx_byte_count <= 8'(MAX_BYTES));
    assign crc_match = (state_q == ST_WAIT_CRC) && crc_valid &&
                       (crc_msgid == msgid_cur) && (crc_sop == 3'(sop_q));
    assign discard_ok = (state_q == ST_CONSTRUCT) || (state_q == ST_SEND) ||
                        (state_q == ST_WAIT_CRC) || (state_q == ST_CHECK_RETRY) ||
                        (state_q == ST_DISCARD);

    // Valid is cut combinationally so an aborting message never sees another byte.
    assign phy_valid = (state_q == ST_SEND) && !rx_discard && !hard_reset;
    assign xfer      = phy_valid && phy_ready;
    assign last_byte = (idx_q == cnt_q - 8'd1);
    assign phy_last  = phy_valid && last_byte;

    // Buffer read is registered, so the address leads the byte on the wire by one cycle.
    always_comb begin
        buf_addr = '0;
        if (state_q == ST_SEND)
            buf_addr = AW'(xfer ? idx_q + 8'd1 : idx_q);
    end

    always_comb begin
        phy_data = '0;
        if (phy_valid) begin
            phy_data = buf_data;
            if (idx_q == 8'd1)
                phy_data[3:1] = msgid_cur;
        end
    end

    assign alert_success   = (state_q == ST_SUCCESS) && !hard_reset;
    assign alert_discarded = (state_q == ST_DISCARD) && !hard_reset;
    assign alert_failed    = ((state_q == ST_FAILURE) || inv_alert_q) && !hard_reset;

    always_comb begin
        state_d     = state_q;
        sop_d       = sop_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        inv_alert_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_req && req_ok) begin
                    sop_d   = SW'(tx_sop);
                    cnt_d   = tx_byte_count;
                    retry_d = '0;
                    state_d = ST_CONSTRUCT;
                end else if (tx_req) begin
                    inv_alert_d = 1'b1;
                end
            end
            ST_CONSTRUCT: begin
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    idx_d = idx_q + 8'd1;
                    if (last_byte) begin
                        timer_d = '0;
                        state_d = ST_WAIT_CRC;
                    end
                end
            end
            ST_WAIT_CRC: begin
                timer_d = timer_q + 12'd1;
                if (crc_match)
                    state_d = ST_SUCCESS;
                else if (timer_q == CRC_TIMEOUT)
                    state_d = ST_CHECK_RETRY;
            end
            ST_CHECK_RETRY: begin
                if (retry_q == RW'(N_RETRY)) begin
                    state_d = ST_FAILURE;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_CONSTRUCT;
                end
            end
            ST_SUCCESS, ST_FAILURE, ST_DISCARD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A GoodCRC landing together with the abort still completes the message.
        if (rx_discard && discard_ok && !crc_match)
            state_d = ST_DISCARD;

        if (hard_reset) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            retry_d     = '0;
            timer_d     = '0;
            inv_alert_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sop_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            inv_alert_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sop_q       <= sop_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            inv_alert_q <= inv_alert_d;
        end
    end

endmodule

// File: tb/tb_pd_prl_tx_engine.sv
// Directed-sequence bench with randomized buffer contents and a frame-level reference model.
module tb_pd_prl_tx_engine;

    localparam int MAXB = 30;
    localparam int NR   = 3;
    localparam int TO   = 273;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       tx_req = 1'b0;
    logic [2:0] tx_sop = '0;
    logic [7:0] tx_byte_count = '0;
    logic [4:0] buf_addr;
    logic [7:0] buf_data = '0;
    logic       phy_valid;
    logic [7:0] phy_data;
    logic       phy_last;
    logic       phy_ready = 1'b1;
    logic       crc_valid = 1'b0;
    logic [2:0] crc_msgid = '0;
    logic [2:0] crc_sop = '0;
    logic       rx_discard = 1'b0;
    logic       hard_reset = 1'b0;
    logic [2:0] msgid;
    logic       busy, alert_success, alert_failed, alert_discarded;

    always #5 CLK = ~CLK;

    pd_prl_tx_engine dut (
        .CLK(CLK), .reset(reset), .tx_req(tx_req), .tx_sop(tx_sop),
        .tx_byte_count(tx_byte_count), .buf_addr(buf_addr), .buf_data(buf_data),
        .phy_valid(phy_valid), .phy_data(phy_data), .phy_last(phy_last),
        .phy_ready(phy_ready), .crc_valid(crc_valid), .crc_msgid(crc_msgid),
        .crc_sop(crc_sop), .rx_discard(rx_discard), .hard_reset(hard_reset),
        .msgid(msgid), .busy(busy), .alert_success(alert_success),
        .alert_failed(alert_failed), .alert_discarded(alert_discarded)
    );

    logic [7:0] mem [32];
    always @(posedge CLK) buf_data <= mem[buf_addr];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int exp_cnt = 4;
    int mid [3];

    // PHY-side observer: collects transferred bytes and frame boundaries.
    logic [7:0] rx_bytes [$];
    int         frame_starts [$];
    int         frame_lasts [$];
    int         n_succ = 0, n_fail = 0, n_disc = 0, stab_err = 0, last_err = 0;
    int         in_idx = 0;
    bit         in_frame = 0, hold_v = 0;
    logic [7:0] hold_d = '0;

    always begin
        @(negedge CLK);
        n_succ = n_succ + int'(alert_success);
        n_fail = n_fail + int'(alert_failed);
        n_disc = n_disc + int'(alert_discarded);
        if (!busy) begin
            in_frame = 0; in_idx = 0; hold_v = 0;
        end else if (phy_valid) begin
            if (hold_v && phy_data !== hold_d) stab_err = stab_err + 1;
            if (!in_frame) begin frame_starts.push_back(cyc); in_frame = 1; end
            if (phy_last !== (in_idx == exp_cnt - 1)) last_err = last_err + 1;
            if (phy_ready) begin
                rx_bytes.push_back(phy_data);
                hold_v = 0;
                in_idx = in_idx + 1;
                if (phy_last) begin frame_lasts.push_back(cyc); in_frame = 0; in_idx = 0; end
            end else begin
                hold_v = 1; hold_d = phy_data;
            end
        end else begin
            hold_v = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int id);
        logic [7:0] b;
        b = mem[i];
        if (i == 1) b[3:1] = 3'(id);
        return b;
    endfunction

    task automatic req(input logic [2:0] s, input logic [7:0] c);
        tx_sop = s; tx_byte_count = c; exp_cnt = int'(c); tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    task automatic crc(input logic [2:0] id, input logic [2:0] s);
        crc_valid = 1'b1; crc_msgid = id; crc_sop = s;
        tick();
        crc_valid = 1'b0;
    endtask

    task automatic wait_last(input int target, input int bound, input string tag);
        int k = 0;
        while (frame_lasts.size() < target && k < bound) begin tick(); k++; end
        chk(tag, frame_lasts.size(), target);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k = 0;
        while (busy && k < bound) begin tick(); k++; end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic check_bytes(input int base, input int c, input int id, input string tag);
        chk({tag, "_len"}, rx_bytes.size() >= base + c, 1);
        if (rx_bytes.size() >= base + c)
            for (int i = 0; i < c; i++)
                chk($sformatf("%s_b%0d", tag, i), 32'(rx_bytes[base + i]), 32'(exp_byte(i, id)));
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(phy_valid), 0);
        chk({tag, "_last"}, 32'(phy_last), 0);
        chk({tag, "_data"}, 32'(phy_data), 0);
        chk({tag, "_addr"}, 32'(buf_addr), 0);
        chk({tag, "_msgid"}, 32'(msgid), 0);
        chk({tag, "_alerts"}, 32'({alert_success, alert_failed, alert_discarded}), 0);
    endtask

    int b0, s0, l0, as0, af0, ad0, c, id;

    task automatic snap();
        b0 = rx_bytes.size(); s0 = frame_starts.size(); l0 = frame_lasts.size();
        as0 = n_succ; af0 = n_fail; ad0 = n_disc;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mid[i] = 0;
        fill_mem();

        // reset state
        tick(); tick();
        zero_outputs("reset");
        reset = 1'b0;
        tick();

        // single frame acknowledged 10 cycles after the last byte
        fill_mem(); snap();
        req(3'd0, 8'd4);
        wait_last(l0 + 1, 100, "succ_last");
        repeat (9) tick();
        crc(3'(mid[0]), 3'd0);
        wait_idle(20, "succ_idle");
        check_bytes(b0, 4, mid[0], "succ");
        chk("succ_frames", frame_starts.size() - s0, 1);
        chk("succ_alert", n_succ - as0, 1);
        chk("succ_nofail", n_fail - af0, 0);
        mid[0] = (mid[0] + 1) % 8;
        chk("succ_msgid", 32'(msgid), 32'(mid[0]));

        // no GoodCRC: N_RETRY+1 attempts spaced by the CRC timer
        fill_mem(); snap();
        c = $urandom_range(2, MAXB);
        req(3'd0, 8'(c));
        wait_idle((NR + 1) * (TO + c + 20), "retry_idle");
        chk("retry_frames", frame_lasts.size() - l0, NR + 1);
        chk("retry_starts", frame_starts.size() - s0, NR + 1);
        for (int f = 0; f <= NR; f++)
            check_bytes(b0 + f * c, c, mid[0], $sformatf("retry_f%0d", f));
        for (int f = 0; f < NR; f++)
            if (frame_starts.size() > s0 + f + 1 && frame_lasts.size() > l0 + f)
                chk($sformatf("retry_gap%0d", f),
                    frame_starts[s0 + f + 1] - frame_lasts[l0 + f] - 1, TO + 3);
        chk("retry_fail_alert", n_fail - af0, 1);
        chk("retry_nosucc", n_succ - as0, 0);
        mid[0] = (mid[0] + 1) % 8;
        chk("retry_msgid", 32'(msgid), 32'(mid[0]));

        // backpressure on a maximum-length frame
        fill_mem(); snap();
        req(3'd2, 8'(MAXB));
        begin
            int k = 0;
            while (frame_lasts.size() < l0 + 1 && k < 4 * MAXB + 20) begin
                phy_ready = ~phy_ready; tick(); k++;
            end
        end
        phy_ready = 1'b1;
        chk("bp_last", frame_lasts.size(), l0 + 1);
        crc(3'(mid[2]), 3'd2);
        wait_idle(20, "bp_idle");
        check_bytes(b0, MAXB, mid[2], "bp");
        chk("bp_stable", stab_err, 0);
        chk("bp_lastpos", last_err, 0);
        chk("bp_alert", n_succ - as0, 1);
        mid[2] = (mid[2] + 1) % 8;
        chk("bp_msgid", 32'(msgid), 32'(mid[2]));

        // mismatched GoodCRCs and a request while busy are ignored
        fill_mem(); snap();
        req(3'd0, 8'd5);
        wait_last(l0 + 1, 100, "mm_last");
        repeat (3) tick();
        crc(3'((mid[0] + 3) % 8), 3'd0);
        crc(3'(mid[0]), 3'd1);
        tx_sop = 3'd1; tx_byte_count = 8'd4; tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        chk("mm_still_busy", 32'(busy), 1);
        repeat (3) tick();
        crc(3'(mid[0]), 3'd0);
        wait_idle(20, "mm_idle");
        chk("mm_frames", frame_starts.size() - s0, 1);
        check_bytes(b0, 5, mid[0], "mm");
        chk("mm_succ", n_succ - as0, 1);
        chk("mm_nofail", n_fail - af0, 0);
        mid[0] = (mid[0] + 1) % 8;
        chk("mm_msgid", 32'(msgid), 32'(mid[0]));

        // rx_discard while byte 2 is on the wire
        fill_mem(); snap();
        req(3'd1, 8'd6);
        begin
            int k = 0;
            while (!phy_valid && k < 10) begin tick(); k++; end
        end
        tick(); tick();
        chk("disc_pre_valid", 32'(phy_valid), 1);
        rx_discard = 1'b1;
        #1;
        chk("disc_valid_same", 32'(phy_valid), 0);
        tick();
        rx_discard = 1'b0;
        chk("disc_valid_next", 32'(phy_valid), 0);
        chk("disc_alert_now", 32'(alert_discarded), 1);
        wait_idle(10, "disc_idle");
        chk("disc_bytes", rx_bytes.size() - b0, 2);
        check_bytes(b0, 2, mid[1], "disc");
        chk("disc_alert", n_disc - ad0, 1);
        chk("disc_noother", (n_succ - as0) + (n_fail - af0), 0);
        chk("disc_msgid", 32'(msgid), 32'(mid[1]));

        // eight successes on SOP' wrap its MessageID
        for (int n = 0; n < 8; n++) begin
            fill_mem(); snap();
            c = $urandom_range(2, MAXB);
            req(3'd1, 8'(c));
            wait_last(l0 + 1, 4 * MAXB, $sformatf("wrap%0d_last", n));
            tick();
            crc(3'(mid[1]), 3'd1);
            wait_idle(20, $sformatf("wrap%0d_idle", n));
            check_bytes(b0, c, mid[1], $sformatf("wrap%0d", n));
            mid[1] = (mid[1] + 1) % 8;
            chk($sformatf("wrap%0d_msgid", n), 32'(msgid), 32'(mid[1]));
        end
        chk("wrap_final_zero", 32'(msgid), 0);

        // hard_reset clears every counter and aborts without alert
        hard_reset = 1'b1; tick(); hard_reset = 1'b0;
        for (int i = 0; i < 3; i++) mid[i] = 0;
        snap();
        for (int s = 0; s < 3; s++) begin
            req(3'(s), 8'd4);
            chk($sformatf("hr%0d_busy", s), 32'(busy), 1);
            chk($sformatf("hr%0d_msgid", s), 32'(msgid), 32'(mid[s]));
            hard_reset = 1'b1;
            #1;
            chk($sformatf("hr%0d_valid", s), 32'(phy_valid), 0);
            tick();
            hard_reset = 1'b0;
            chk($sformatf("hr%0d_idle", s), 32'(busy), 0);
        end
        tick();
        chk("hr_no_alerts", (n_succ - as0) + (n_fail - af0) + (n_disc - ad0), 0);
        fill_mem(); snap();
        req(3'd0, 8'd2);
        wait_last(l0 + 1, 50, "hr_min_last");
        crc(3'(mid[0]), 3'd0);
        wait_idle(20, "hr_min_idle");
        check_bytes(b0, 2, mid[0], "hr_min");
        chk("hr_min_succ", n_succ - as0, 1);
        mid[0] = (mid[0] + 1) % 8;

        // async reset in the middle of WAIT_CRC
        fill_mem();
        req(3'd2, 8'd3);
        wait_last(frame_lasts.size() + 1, 50, "ar_last");
        repeat (5) tick();
        chk("ar_waiting", 32'(busy), 1);
        reset = 1'b1;
        #1;
        zero_outputs("areset");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) mid[i] = 0;
        tick();

        // rejected requests: bad SOP* and out-of-range byte counts
        snap();
        req(3'd3, 8'd4);
        chk("inv_sop_alert", 32'(alert_failed), 1);
        chk("inv_sop_busy", 32'(busy), 0);
        tick();
        chk("inv_sop_pulse", 32'(alert_failed), 0);
        req(3'd0, 8'd1);
        chk("inv_cnt1_alert", 32'(alert_failed), 1);
        tick();
        req(3'd0, 8'(MAXB + 1));
        chk("inv_cnt31_alert", 32'(alert_failed), 1);
        repeat (5) tick();
        chk("inv_no_frames", frame_starts.size() - s0, 0);
        chk("inv_idle", 32'(busy), 0);
        chk("inv_fail_cnt", n_fail - af0, 3);

        chk("all_stable", stab_err, 0);
        chk("all_lastpos", last_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
